// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// datapath select codes and the bundled control-word struct.
package cpu_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_JAL   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_BRANCH = 3'd3,
        S_MEM    = 3'd4,
        S_MEMWB  = 3'd5,
        S_ALUWB  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_BRT  = 2'b01;
    localparam logic [1:0] PC_JUMP = 2'b10;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BRT = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_R7 = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       halted;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles, saturating at MAX; expired flags the
// cycle in which one more stall would exceed the tolerated wait.
module mem_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (count_en && cnt_q != W'(MAX))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == W'(MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/
// write-back, with a memory-stall timeout that parks the core in HALT.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPC_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err,
    output logic             retire
);
    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             err_q, err_d;
    logic             expired;
    ctrl_t            ctl;
    logic [2:0]       op_now, op_lat;

    assign op_now = opcode[2:0];
    assign op_lat = opc_q[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        err_d   = err_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else if (expired) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_DECODE: begin
                opc_d = opcode;
                case (op_now)
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
                    OP_BEQ:                          state_d = S_BRANCH;
                    OP_J, OP_JAL:                    state_d = S_FETCH;
                    default:                         state_d = S_HALT;
                endcase
            end
            S_EXEC:   state_d = (op_lat == OP_LW || op_lat == OP_SW) ? S_MEM : S_ALUWB;
            S_BRANCH: state_d = S_FETCH;
            S_MEM: begin
                if (mem_ready) state_d = (op_lat == OP_LW) ? S_MEMWB : S_FETCH;
                else if (expired) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_ALUWB:  state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // Only DECODE may look at the live opcode; later states use the latch.
    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_ONE;
                ctl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = PC_ALU;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_BRT;
                if (op_now == OP_J || op_now == OP_JAL) begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = PC_JUMP;
                    ctl.retire   = 1'b1;
                end
                if (op_now == OP_JAL) begin
                    ctl.reg_write  = 1'b1;
                    ctl.reg_dst    = DST_R7;
                    ctl.mem_to_reg = WB_PC;
                end
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                if (op_lat == OP_RTYPE) begin
                    ctl.alu_src_b = SRCB_RT;
                    ctl.alu_op    = ALU_FUNCT;
                end else begin
                    ctl.alu_src_b = SRCB_IMM;
                    ctl.alu_op    = ALU_ADD;
                end
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_src    = PC_BRT;
                ctl.pc_write  = zero;
                ctl.retire    = 1'b1;
            end
            S_MEM: begin
                ctl.mem_req   = 1'b1;
                ctl.i_or_d    = 1'b1;
                ctl.mem_read  = (op_lat == OP_LW);
                ctl.mem_write = (op_lat == OP_SW);
                ctl.retire    = mem_ready && (op_lat == OP_SW);
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = DST_RT;
                ctl.mem_to_reg = WB_MEM;
                ctl.retire     = 1'b1;
            end
            S_ALUWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = WB_ALU;
                ctl.reg_dst    = (op_lat == OP_RTYPE) ? DST_RD : DST_RT;
                ctl.retire     = 1'b1;
            end
            default: ctl.halted = 1'b1;
        endcase
    end

    mem_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (mem_ready || (state_d != state_q)),
        .count_en (ctl.mem_req && !mem_ready),
        .expired  (expired)
    );

    assign mem_req    = ctl.mem_req;
    assign mem_read   = ctl.mem_read;
    assign mem_write  = ctl.mem_write;
    assign i_or_d     = ctl.i_or_d;
    assign ir_write   = ctl.ir_write;
    assign pc_write   = ctl.pc_write;
    assign pc_src     = ctl.pc_src;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign reg_write  = ctl.reg_write;
    assign halted     = ctl.halted;
    assign retire     = ctl.retire;
    assign state      = state_q;
    assign err        = err_q;

endmodule
